// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register load-use scoreboard.
// Optional RF_DEBUG_PORT_EN adds a non-bypassed debug read port and the busy vector.
module id_regfile_scoreboard #(
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned N_REG_BITS = 5,
  parameter int unsigned N_RD_PORTS = 2,
  parameter int unsigned LOAD_LAT   = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_regWrite,
  input  logic [N_REG_BITS-1:0]            i_dato_a_escribir_addr,
  input  logic [N_BITS-1:0]                i_WB_data_to_w,
  input  logic [N_RD_PORTS*N_REG_BITS-1:0] i_rd_addr,
  output logic [N_RD_PORTS*N_BITS-1:0]     o_dato_leido,
  input  logic                             i_issue_valid,
  input  logic                             i_issue_is_load,
  input  logic [N_REG_BITS-1:0]            i_issue_rd,
  input  logic                             i_flush,
`ifdef RF_DEBUG_PORT_EN
  input  logic [N_REG_BITS-1:0]            i_dbg_addr,
  output logic [N_BITS-1:0]                o_dbg_data,
  output logic [2**N_REG_BITS-1:0]         o_busy_vec,
`endif
  output logic                             o_stall
);

  localparam int unsigned NumRegs = 2**N_REG_BITS;
  localparam int unsigned CntW    = $clog2(LOAD_LAT + 1);

  logic [N_BITS-1:0] regs_q [NumRegs];
  logic [CntW-1:0]   cnt_q  [NumRegs];
  logic [NumRegs-1:0] busy;
  logic               wr_en;
  logic               hazard;
  logic               accept;
  logic               load_set;

  assign wr_en = i_regWrite && (i_dato_a_escribir_addr != '0);

  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < N_RD_PORTS; k++) begin
      hazard = hazard | busy[i_rd_addr[k*N_REG_BITS +: N_REG_BITS]];
    end
  end

  assign o_stall  = i_issue_valid && !i_flush && hazard;
  assign accept   = i_issue_valid && !i_flush && !hazard;
  assign load_set = accept && i_issue_is_load && (i_issue_rd != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      if (wr_en) begin
        regs_q[i_dato_a_escribir_addr] <= i_WB_data_to_w;
      end
      // Load accept outranks a same-cycle write-back clear, which outranks decrement.
      for (int r = 0; r < NumRegs; r++) begin
        if (load_set && (i_issue_rd == N_REG_BITS'(r))) begin
          cnt_q[r] <= CntW'(LOAD_LAT);
        end else if (i_regWrite && (i_dato_a_escribir_addr == N_REG_BITS'(r))) begin
          cnt_q[r] <= '0;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_RD_PORTS; k++) begin : g_rd
    logic [N_REG_BITS-1:0] addr;
    logic [N_BITS-1:0]     data;

    assign addr = i_rd_addr[k*N_REG_BITS +: N_REG_BITS];

    always_comb begin
      if (addr == '0) begin
        data = '0;
      end else if (wr_en && (addr == i_dato_a_escribir_addr)) begin
        data = i_WB_data_to_w;
      end else begin
        data = regs_q[addr];
      end
    end

    assign o_dato_leido[k*N_BITS +: N_BITS] = data;
  end

`ifdef RF_DEBUG_PORT_EN
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
  assign o_busy_vec = busy;
`endif

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Self-checking bench for id_regfile_scoreboard: directed scenarios plus random traffic
// compared against an array-based model of registers and remaining load-busy cycles.
module tb_id_regfile_scoreboard;

  localparam int unsigned N   = 32;
  localparam int unsigned RB  = 5;
  localparam int unsigned P   = 2;
  localparam int unsigned LAT = 2;
  localparam int unsigned NR  = 2**RB;

  logic                   i_clk = 1'b0;
  logic                   i_reset;
  logic                   we;
  logic [RB-1:0]          waddr;
  logic [N-1:0]           wdata;
  logic [P-1:0][RB-1:0]   rd_a;
  logic [P*N-1:0]         o_dato_leido;
  logic                   iv;
  logic                   il;
  logic [RB-1:0]          ird;
  logic                   fl;
  logic                   o_stall;
`ifdef RF_DEBUG_PORT_EN
  logic [RB-1:0]          dbg_addr;
  logic [N-1:0]           o_dbg_data;
  logic [NR-1:0]          o_busy_vec;
`endif

  always #5 i_clk = ~i_clk;

  id_regfile_scoreboard #(
    .N_BITS    (N),
    .N_REG_BITS(RB),
    .N_RD_PORTS(P),
    .LOAD_LAT  (LAT)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_regWrite            (we),
    .i_dato_a_escribir_addr(waddr),
    .i_WB_data_to_w        (wdata),
    .i_rd_addr             (rd_a),
    .o_dato_leido          (o_dato_leido),
    .i_issue_valid         (iv),
    .i_issue_is_load       (il),
    .i_issue_rd            (ird),
    .i_flush               (fl),
`ifdef RF_DEBUG_PORT_EN
    .i_dbg_addr            (dbg_addr),
    .o_dbg_data            (o_dbg_data),
    .o_busy_vec            (o_busy_vec),
`endif
    .o_stall               (o_stall)
  );

  // Model: architectural register values and cycles each register remains load-busy.
  logic [N-1:0] mreg [NR];
  int           mleft [NR];
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_read(input int a);
    if (a == 0) return '0;
    if (we && waddr != 0 && int'(waddr) == a) return wdata;
    return mreg[a];
  endfunction

  task automatic idle();
    i_reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rd_a = '0; iv = 1'b0; il = 1'b0; ird = '0; fl = 1'b0;
`ifdef RF_DEBUG_PORT_EN
    dbg_addr = '0;
`endif
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic tick();
    bit any_busy;
    bit exp_stall;
    bit accept;
    int a;
    #1;
    any_busy = 1'b0;
    for (int k = 0; k < P; k++) begin
      a = int'(rd_a[k]);
      chk("rd_port", o_dato_leido[k*N +: N], model_read(a));
      if (mleft[a] > 0) any_busy = 1'b1;
    end
    exp_stall = iv && !fl && any_busy;
    chk("stall", {31'b0, o_stall}, {31'b0, exp_stall});
`ifdef RF_DEBUG_PORT_EN
    for (int r = 0; r < NR; r++) begin
      if ((o_busy_vec[r] == 1'b1) != (mleft[r] > 0)) begin
        chk("busy_vec", o_busy_vec, '1 ^ o_busy_vec);
        break;
      end
    end
    chk("dbg_data", o_dbg_data, mreg[int'(dbg_addr)]);
`endif
    @(posedge i_clk);
    if (i_reset) begin
      for (int r = 0; r < NR; r++) begin
        mreg[r] = '0;
        mleft[r] = 0;
      end
    end else begin
      accept = iv && !fl && !exp_stall;
      for (int r = 0; r < NR; r++) begin
        if (accept && il && ird != 0 && int'(ird) == r) mleft[r] = LAT;
        else if (we && int'(waddr) == r) mleft[r] = 0;
        else if (mleft[r] > 0) mleft[r] = mleft[r] - 1;
      end
      if (we && waddr != 0) mreg[waddr] = wdata;
    end
    @(negedge i_clk);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      mreg[r] = 'x;
      mleft[r] = 0;
    end
    idle();
    i_reset = 1'b1;
    @(negedge i_clk);
    tick();
    tick();
    idle();

    // Reset state
    rd_a[0] = 5'd3; rd_a[1] = 5'd31; iv = 1'b1;
    #1;
    chk("reset_r3", o_dato_leido[0 +: N], '0);
    chk("reset_r31", o_dato_leido[N +: N], '0);
    chk("reset_stall", {31'b0, o_stall}, '0);
    tick();

    // Write-through bypass then array read
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_10F3; rd_a[0] = 5'd3;
    #1;
    chk("bypass_r3", o_dato_leido[0 +: N], 32'h0000_10F3);
    tick();
    idle();
    rd_a[0] = 5'd3;
    #1;
    chk("array_r3", o_dato_leido[0 +: N], 32'h0000_10F3);
    tick();

    // Writes to r0 are ignored
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    #1;
    chk("r0_bypass_p0", o_dato_leido[0 +: N], '0);
    chk("r0_bypass_p1", o_dato_leido[N +: N], '0);
    tick();
    idle();
    #1;
    chk("r0_after", o_dato_leido[0 +: N], '0);
    tick();

    // Load-use stall lasts LOAD_LAT cycles
    idle();
    iv = 1'b1; il = 1'b1; ird = 5'd3;
    tick();
    idle();
    iv = 1'b1; ird = 5'd9; rd_a[1] = 5'd3;
    #1;
    chk("lu_stall_1", {31'b0, o_stall}, 32'd1);
    tick();
    #1;
    chk("lu_stall_2", {31'b0, o_stall}, 32'd1);
    tick();
    #1;
    chk("lu_stall_done", {31'b0, o_stall}, 32'd0);
    tick();

    // Early write-back clears the counter
    idle();
    iv = 1'b1; il = 1'b1; ird = 5'd5;
    tick();
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'h55;
    tick();
    idle();
    iv = 1'b1; rd_a[0] = 5'd5;
    #1;
    chk("wb_clear_stall", {31'b0, o_stall}, 32'd0);
    chk("wb_clear_data", o_dato_leido[0 +: N], 32'h55);
    tick();

    // Flushed load sets nothing
    idle();
    iv = 1'b1; il = 1'b1; ird = 5'd7; fl = 1'b1;
    tick();
    idle();
    iv = 1'b1; rd_a[0] = 5'd7;
    #1;
    chk("flush_stall", {31'b0, o_stall}, 32'd0);
    tick();

    // Load accept beats same-cycle write-back, then reset drops everything
    idle();
    iv = 1'b1; il = 1'b1; ird = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'hAB;
    tick();
    idle();
    iv = 1'b1; rd_a[0] = 5'd4;
    #1;
    chk("set_over_clear", {31'b0, o_stall}, 32'd1);
    idle();
    i_reset = 1'b1;
    tick();
    idle();
    iv = 1'b1; rd_a[0] = 5'd4;
    #1;
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_r4", o_dato_leido[0 +: N], '0);
`ifdef RF_DEBUG_PORT_EN
    chk("rst_busy_vec", o_busy_vec, '0);
`endif
    tick();

    // Random traffic on a narrow address range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      idle();
      i_reset = ($urandom_range(99) < 2);
      we      = ($urandom_range(99) < 35);
      waddr   = RB'($urandom_range(7));
      wdata   = $urandom;
      for (int k = 0; k < P; k++) rd_a[k] = RB'($urandom_range(7));
      iv      = ($urandom_range(99) < 70);
      il      = ($urandom_range(99) < 50);
      ird     = RB'($urandom_range(7));
      fl      = ($urandom_range(99) < 10);
`ifdef RF_DEBUG_PORT_EN
      dbg_addr = RB'($urandom_range(7));
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
